product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/pa_pkg.sv | 14 +
 rtl/pa_acc_add.sv | 18 +
 rtl/product_accumulator.sv | 100 ++++++++++
 tb/tb_product_accumulator.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pa_pkg.sv
// rtl/pa_pkg.sv - shared state encoding and default widths for the product accumulator
package pa_pkg;

    localparam int PA_PROD_W = 32;
    localparam int PA_ACC_W  = 40;
    localparam int PA_LEN_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } pa_state_e;

endpackage

// File: rtl/pa_acc_add.sv
// rtl/pa_acc_add.sv - ACC_W adder of accumulator and zero-extended product with carry out
module pa_acc_add #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] product,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] wide_sum;

    assign wide_sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};
    assign sum      = wide_sum[ACC_W-1:0];
    assign carry    = wide_sum[ACC_W];

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - burst product accumulator (IDLE/ACCUM/OUT)
// Define PA_SATURATE_EN to clamp on overflow instead of wrapping.
module product_accumulator
    import pa_pkg::*;
#(
    parameter int PROD_W = PA_PROD_W,
    parameter int ACC_W  = PA_ACC_W,
    parameter int LEN_W  = PA_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf,
    output logic              busy
);

    // Counter is one bit wider so cfg_len==0 can load the full 2^LEN_W burst.
    localparam logic [LEN_W:0] CNT_ONE  = (LEN_W + 1)'(1);
    localparam logic [LEN_W:0] CNT_FULL = {1'b1, {LEN_W{1'b0}}};

    pa_state_e        state;
    pa_state_e        state_next;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic             carry;
    logic             ovf;
    logic [LEN_W:0]   remaining;
    logic             accept;
    logic             last_accept;

    pa_acc_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc     (acc),
        .product (in_product),
        .sum     (sum),
        .carry   (carry)
    );

    assign in_ready    = (state == ST_ACCUM);
    assign out_valid   = (state == ST_OUT);
    assign busy        = (state != ST_IDLE);
    assign out_acc     = acc;
    assign out_ovf     = ovf;
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (remaining == CNT_ONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start)       state_next = ST_ACCUM;
            ST_ACCUM: if (last_accept) state_next = ST_OUT;
            ST_OUT:   if (out_ready)   state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            ovf       <= 1'b0;
            remaining <= '0;
        end else if (state == ST_IDLE && start) begin
            acc       <= '0;
            ovf       <= 1'b0;
            remaining <= (cfg_len == '0) ? CNT_FULL : {1'b0, cfg_len};
        end else if (accept) begin
            remaining <= remaining - CNT_ONE;
`ifdef PA_SATURATE_EN
            // Once clamped, the sum stays pinned at all-ones until the next burst.
            if (carry || ovf) begin
                acc <= '1;
                ovf <= 1'b1;
            end else begin
                acc <= sum;
            end
`else
            acc <= sum;
            ovf <= ovf | carry;
`endif
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - scoreboard bench for product_accumulator
module tb_product_accumulator;

    typedef struct {
        logic [63:0] acc;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cfg_len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_product = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [39:0] out_acc;
    logic        out_ovf;
    logic        busy;

    logic        s_start = 1'b0;
    logic [7:0]  s_len = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_prod = '0;
    logic        s_out_valid;
    logic        s_out_ready = 1'b1;
    logic [31:0] s_acc;
    logic        s_ovf;
    logic        s_busy;

    always #5 clk = ~clk;

    product_accumulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_len    (cfg_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_product (in_product),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_acc    (out_acc),
        .out_ovf    (out_ovf),
        .busy       (busy)
    );

    product_accumulator #(.ACC_W(32)) dut32 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (s_start),
        .cfg_len    (s_len),
        .in_valid   (s_valid),
        .in_ready   (s_ready),
        .in_product (s_prod),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .out_acc    (s_acc),
        .out_ovf    (s_ovf),
        .busy       (s_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready"},  64'(in_ready),  64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_out_acc"},   64'(out_acc),   64'd0);
        check({tag, "_out_ovf"},   64'(out_ovf),   64'd0);
    endtask

    task automatic begin_burst(input logic [7:0] len, input logic [63:0] acc, input logic ovf);
        exp_t e;
        e.acc = acc;
        e.ovf = ovf;
        sb.push_back(e);
        start   = 1'b1;
        cfg_len = len;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [31:0] p, input int gap);
        repeat (gap) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid   = 1'b1;
        in_product = p;
        tick();
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL sb_unexpected_result observed=%0h expected=none", out_acc);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("sb_acc", 64'(out_acc), e.acc);
                check("sb_ovf", 64'(out_ovf), 64'(e.ovf));
            end
        end
    end

    initial begin
        repeat (3) tick();
        check_idle_zero("reset");
        rst_n = 1'b1;
        tick();

        // three products back-to-back
        begin_burst(8'd3, 64'd21, 1'b0);
        check("accum_in_ready", 64'(in_ready), 64'd1);
        feed(32'd5, 0);
        feed(32'd7, 0);
        check("b1_not_done", 64'(out_valid), 64'd0);
        feed(32'd9, 0);
        check("b1_latency", 64'(out_valid), 64'd1);
        check("b1_in_ready_out", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        tick();
        check("b1_idle", 64'(busy), 64'd0);

        // gaps between products do not count
        begin_burst(8'd2, 64'h01_0000_0000, 1'b0);
        feed(32'hFFFF_FFFF, 3);
        feed(32'h0000_0001, 3);
        in_valid = 1'b0;
        check("b2_latency", 64'(out_valid), 64'd1);
        tick();

        // result held under back-pressure, start ignored
        out_ready = 1'b0;
        begin_burst(8'd2, 64'd30, 1'b0);
        feed(32'd10, 0);
        feed(32'd20, 0);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            start   = (i == 4);
            cfg_len = 8'd1;
            check("hold_acc", 64'(out_acc), 64'd30);
            check("hold_valid", 64'(out_valid), 64'd1);
            tick();
        end
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        check("hold_release_valid", 64'(out_valid), 64'd0);
        check("hold_release_busy", 64'(busy), 64'd0);

        // cfg_len 0 means 256 products
        begin_burst(8'd0, 64'd256, 1'b0);
        for (int i = 0; i < 255; i++) feed(32'd1, 0);
        check("full_not_done", 64'(out_valid), 64'd0);
        feed(32'd1, 0);
        in_valid = 1'b0;
        check("full_done", 64'(out_valid), 64'd1);
        tick();

        // overflow on the 32-bit accumulator
        s_start = 1'b1;
        s_len   = 8'd2;
        tick();
        s_start = 1'b0;
        s_valid = 1'b1;
        s_prod  = 32'hFFFF_FFFF;
        tick();
        s_prod  = 32'h0000_0002;
        tick();
        s_valid = 1'b0;
        check("ovf_valid", 64'(s_out_valid), 64'd1);
`ifdef PA_SATURATE_EN
        check("ovf_acc", 64'(s_acc), 64'hFFFF_FFFF);
`else
        check("ovf_acc", 64'(s_acc), 64'h0000_0001);
`endif
        check("ovf_flag", 64'(s_ovf), 64'd1);
        tick();
        check("ovf_idle", 64'(s_busy), 64'd0);

        // reset mid-burst discards it
        start   = 1'b1;
        cfg_len = 8'd4;
        tick();
        start = 1'b0;
        feed(32'd3, 0);
        feed(32'd3, 0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        check_idle_zero("midreset");
        rst_n = 1'b1;
        tick();
        begin_burst(8'd1, 64'd4, 1'b0);
        feed(32'd4, 0);
        in_valid = 1'b0;
        check("after_reset_valid", 64'(out_valid), 64'd1);
        tick();
        tick();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
